// File: rtl/perf_counter_bank.sv
// Multi-channel cycle/performance counter bank watching the register-writeback bus.
// Per-channel IDLE/RUN/DONE control with tick-gated saturating counters, snapshots and indexed readout.
module perf_counter_bank #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DIV_LOG2   = 1,
    parameter int unsigned LED_W      = 3,
    parameter bit          AUTO_START = 1'b1,
    localparam int unsigned SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_en,
    input  logic [4:0]                wb_rd,
    input  logic [WIDTH-1:0]          wb_data,
    input  logic [NUM_CH*5-1:0]       cfg_rd,
    input  logic [NUM_CH*WIDTH-1:0]   cfg_data,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         clr,
    input  logic                      snap,
    input  logic [SEL_W-1:0]          rd_sel,
    output logic                      tick_out,
    output logic [LED_W-1:0]          led_out,
    output logic [WIDTH-1:0]          rd_count,
    output logic [WIDTH-1:0]          rd_snap,
    output logic [NUM_CH-1:0]         running,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam state_t RST_STATE = AUTO_START ? ST_RUN : ST_IDLE;

    logic                 w_tick;
    logic [LED_W-1:0]     r_led;
    logic [NUM_CH-1:0]    w_match;

    state_t               r_state     [NUM_CH];
    state_t               w_state_nxt [NUM_CH];
    logic [WIDTH-1:0]     r_count     [NUM_CH];
    logic [WIDTH-1:0]     w_count_nxt [NUM_CH];
    logic [WIDTH-1:0]     r_snap      [NUM_CH];
    logic [NUM_CH-1:0]    r_ovf;
    logic [NUM_CH-1:0]    w_ovf_nxt;

    // Clock-enable divider: tick on the all-ones phase, or every cycle with no divider.
    generate
        if (DIV_LOG2 == 0) begin : g_no_div
            assign w_tick = 1'b1;
        end else begin : g_div
            logic [DIV_LOG2-1:0] r_div_cnt;
            always_ff @(posedge clk) begin
                if (rst) r_div_cnt <= '0;
                else     r_div_cnt <= r_div_cnt + DIV_LOG2'(1);
            end
            assign w_tick = &r_div_cnt;
        end
    endgenerate

    assign tick_out = w_tick;

    always_ff @(posedge clk) begin
        if (rst) r_led <= '0;
        else     r_led <= r_led + LED_W'(1);
    end

    assign led_out = r_led;

    always_comb begin
        w_match = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_match[i] = wb_en && (wb_rd == cfg_rd[5*i +: 5])
                               && (wb_data == cfg_data[WIDTH*i +: WIDTH]);
        end
    end

    // Channel next-state: clr beats start, start beats the stop match.
    always_comb begin
        w_ovf_nxt = r_ovf;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_count_nxt[i] = r_count[i];
            if (clr[i]) begin
                w_state_nxt[i] = ST_IDLE;
                w_count_nxt[i] = '0;
                w_ovf_nxt[i]   = 1'b0;
            end else if (start[i]) begin
                w_state_nxt[i] = ST_RUN;
                w_count_nxt[i] = '0;
                w_ovf_nxt[i]   = 1'b0;
            end else if (r_state[i] == ST_RUN) begin
                if (w_tick) begin
                    if (&r_count[i]) w_ovf_nxt[i]   = 1'b1;
                    else             w_count_nxt[i] = r_count[i] + WIDTH'(1);
                end
                if (w_match[i]) w_state_nxt[i] = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_state[i] <= RST_STATE;
                r_count[i] <= '0;
                r_snap[i]  <= '0;
            end
        end else begin
            r_ovf <= w_ovf_nxt;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_count[i] <= w_count_nxt[i];
                if (snap) r_snap[i] <= r_count[i];
            end
        end
    end

    assign ovf = r_ovf;

    // Zero-latency readout; an out-of-range select reads zero.
    always_comb begin
        rd_count = '0;
        rd_snap  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_count = r_count[i];
                rd_snap  = r_snap[i];
            end
        end
    end

    always_comb begin
        running = '0;
        done    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            running[i] = (r_state[i] == ST_RUN);
            done[i]    = (r_state[i] == ST_DONE);
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: directed scenarios, a vector table and a randomized run against a model.
module tb_perf_counter_bank;

    localparam int AN = 3;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: WIDTH=32, NUM_CH=3, DIV_LOG2=1, AUTO_START=1
    logic        a_rst, a_wb_en, a_snap;
    logic [4:0]  a_wb_rd;
    logic [31:0] a_wb_data;
    logic [14:0] a_cfg_rd;
    logic [95:0] a_cfg_data;
    logic [2:0]  a_start, a_clr;
    logic [1:0]  a_rd_sel;
    logic        a_tick;
    logic [2:0]  a_led;
    logic [31:0] a_rd_count, a_rd_snap;
    logic [2:0]  a_running, a_done, a_ovf;

    perf_counter_bank #(.WIDTH(32), .NUM_CH(3), .DIV_LOG2(1), .LED_W(3), .AUTO_START(1'b1)) u_dut_a (
        .clk(clk), .rst(a_rst), .wb_en(a_wb_en), .wb_rd(a_wb_rd), .wb_data(a_wb_data),
        .cfg_rd(a_cfg_rd), .cfg_data(a_cfg_data), .start(a_start), .clr(a_clr),
        .snap(a_snap), .rd_sel(a_rd_sel), .tick_out(a_tick), .led_out(a_led),
        .rd_count(a_rd_count), .rd_snap(a_rd_snap), .running(a_running),
        .done(a_done), .ovf(a_ovf)
    );

    // Instance B: WIDTH=4, NUM_CH=4, DIV_LOG2=0, AUTO_START=0
    logic        b_rst, b_wb_en, b_snap;
    logic [4:0]  b_wb_rd;
    logic [3:0]  b_wb_data;
    logic [19:0] b_cfg_rd;
    logic [15:0] b_cfg_data;
    logic [3:0]  b_start, b_clr;
    logic [1:0]  b_rd_sel;
    logic        b_tick;
    logic [2:0]  b_led;
    logic [3:0]  b_rd_count, b_rd_snap;
    logic [3:0]  b_running, b_done, b_ovf;

    perf_counter_bank #(.WIDTH(4), .NUM_CH(4), .DIV_LOG2(0), .LED_W(3), .AUTO_START(1'b0)) u_dut_b (
        .clk(clk), .rst(b_rst), .wb_en(b_wb_en), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
        .cfg_rd(b_cfg_rd), .cfg_data(b_cfg_data), .start(b_start), .clr(b_clr),
        .snap(b_snap), .rd_sel(b_rd_sel), .tick_out(b_tick), .led_out(b_led),
        .rd_count(b_rd_count), .rd_snap(b_rd_snap), .running(b_running),
        .done(b_done), .ovf(b_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model of instance A: plain counts per channel, tick derived from edges since reset.
    longint unsigned m_cnt  [AN];
    longint unsigned m_snap [AN];
    int              m_st   [AN];   // 0 idle, 1 run, 2 done
    bit              m_ovf  [AN];
    int              m_cyc;

    task automatic model_edge();
        bit tk, mt;
        if (a_rst) begin
            for (int i = 0; i < AN; i++) begin
                m_cnt[i] = 0; m_snap[i] = 0; m_st[i] = 1; m_ovf[i] = 0;
            end
            m_cyc = 0;
            return;
        end
        tk = (m_cyc % 2) == 1;
        if (a_snap) for (int i = 0; i < AN; i++) m_snap[i] = m_cnt[i];
        for (int i = 0; i < AN; i++) begin
            mt = a_wb_en && (a_wb_rd == a_cfg_rd[5*i +: 5]) && (a_wb_data == a_cfg_data[32*i +: 32]);
            if (a_clr[i]) begin
                m_st[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
            end else if (a_start[i]) begin
                m_st[i] = 1; m_cnt[i] = 0; m_ovf[i] = 0;
            end else if (m_st[i] == 1) begin
                if (tk) begin
                    if (m_cnt[i] == 64'hFFFF_FFFF) m_ovf[i] = 1;
                    else                           m_cnt[i] = m_cnt[i] + 1;
                end
                if (mt) m_st[i] = 2;
            end
        end
        m_cyc++;
    endtask

    task automatic a_cycle();
        model_edge();
        @(negedge clk);
    endtask

    task automatic a_idle(input int n);
        a_wb_en = 1'b0; a_start = '0; a_clr = '0; a_snap = 1'b0;
        repeat (n) a_cycle();
    endtask

    task automatic a_reset();
        a_rst = 1'b1;
        a_idle(1);
        a_rst = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] ec, es;
        logic [2:0]  er, ed, eo;
        ec = 0; es = 0;
        if (int'(a_rd_sel) < AN) begin
            ec = 32'(m_cnt[a_rd_sel]);
            es = 32'(m_snap[a_rd_sel]);
        end
        for (int i = 0; i < AN; i++) begin
            er[i] = (m_st[i] == 1);
            ed[i] = (m_st[i] == 2);
            eo[i] = m_ovf[i];
        end
        chk({tag, ".count"}, a_rd_count, ec);
        chk({tag, ".snap"}, a_rd_snap, es);
        chk({tag, ".running"}, a_running, er);
        chk({tag, ".done"}, a_done, ed);
        chk({tag, ".ovf"}, a_ovf, eo);
        chk({tag, ".tick"}, a_tick, 64'((m_cyc % 2) == 1));
        chk({tag, ".led"}, a_led, 64'(m_cyc % 8));
    endtask

    typedef struct {
        logic [3:0] start;
        logic [3:0] clr;
        logic       snap;
        logic [1:0] sel;
        logic [3:0] cnt;
        logic [3:0] snp;
        logic [3:0] run;
        logic [3:0] dn;
        logic [3:0] ov;
    } vec_t;

    vec_t tbl [6];

    initial begin
        a_rst = 1'b1; a_wb_en = 0; a_wb_rd = 0; a_wb_data = 0; a_start = 0; a_clr = 0;
        a_snap = 0; a_rd_sel = 0;
        a_cfg_rd   = {5'd6, 5'd5, 5'd31};
        a_cfg_data = {32'd88, 32'd77, 32'd400};
        b_rst = 1'b1; b_wb_en = 0; b_wb_rd = 5'd31; b_wb_data = 0; b_start = 0; b_clr = 0;
        b_snap = 0; b_rd_sel = 0; b_cfg_rd = '0; b_cfg_data = '0;

        tbl[0] = '{start:4'b0011, clr:4'b0000, snap:0, sel:0, cnt:0, snp:0, run:4'b0011, dn:0, ov:0};
        tbl[1] = '{start:4'b0000, clr:4'b0000, snap:0, sel:0, cnt:1, snp:0, run:4'b0011, dn:0, ov:0};
        tbl[2] = '{start:4'b0000, clr:4'b0000, snap:1, sel:0, cnt:2, snp:1, run:4'b0011, dn:0, ov:0};
        tbl[3] = '{start:4'b0001, clr:4'b0001, snap:0, sel:0, cnt:0, snp:1, run:4'b0010, dn:0, ov:0};
        tbl[4] = '{start:4'b0000, clr:4'b0000, snap:0, sel:0, cnt:0, snp:1, run:4'b0010, dn:0, ov:0};
        tbl[5] = '{start:4'b0000, clr:4'b0000, snap:0, sel:1, cnt:5, snp:1, run:4'b0010, dn:0, ov:0};

        a_idle(2);
        chk("a_rst.count", a_rd_count, 0);
        chk("a_rst.snap", a_rd_snap, 0);
        chk("a_rst.running", a_running, 3'b111);
        chk("a_rst.done", a_done, 0);
        chk("a_rst.ovf", a_ovf, 0);
        chk("a_rst.tick", a_tick, 0);
        chk("a_rst.led", a_led, 0);
        chk("b_rst.running", b_running, 0);
        chk("b_rst.count", b_rd_count, 0);
        chk("b_rst.tick", b_tick, 1);
        a_rst = 1'b0;

        // Stop match on the 20th edge after reset release
        a_idle(19);
        a_wb_en = 1'b1; a_wb_rd = 5'd31; a_wb_data = 32'd400;
        a_cycle();
        a_wb_en = 1'b0;
        chk("stop.count", a_rd_count, 10);
        chk("stop.done", a_done[0], 1);
        chk("stop.running", a_running[0], 0);
        a_idle(50);
        chk("stop.frozen", a_rd_count, 10);
        check_model("stop");

        // Near-miss writebacks must not stop the channel
        a_reset();
        a_idle(5);
        a_wb_en = 1'b1; a_wb_rd = 5'd31; a_wb_data = 32'd399; a_cycle();
        a_wb_rd = 5'd30; a_wb_data = 32'd400; a_cycle();
        a_wb_en = 1'b0; a_wb_rd = 5'd31; a_wb_data = 32'd400; a_cycle();
        a_idle(3);
        chk("miss.running", a_running[0], 1);
        chk("miss.count", a_rd_count, 5);
        a_idle(1);
        chk("miss.count2", a_rd_count, 6);

        // Snapshot of ch2 at 7 while the live count continues
        a_reset();
        a_rd_sel = 2'd2;
        a_idle(14);
        chk("snap.pre", a_rd_count, 7);
        a_snap = 1'b1; a_cycle(); a_snap = 1'b0;
        chk("snap.val", a_rd_snap, 7);
        a_idle(1);
        chk("snap.live8", a_rd_count, 8);
        chk("snap.hold", a_rd_snap, 7);
        a_idle(2);
        chk("snap.live9", a_rd_count, 9);

        // clr and start together on ch1 at count 9: clr wins
        a_rd_sel = 2'd1;
        chk("clrst.pre", a_rd_count, 9);
        a_clr = 3'b010; a_start = 3'b010; a_cycle();
        chk("clrst.count", a_rd_count, 0);
        chk("clrst.running", a_running[1], 0);
        chk("clrst.done", a_done[1], 0);
        a_idle(4);
        chk("clrst.noinc", a_rd_count, 0);
        check_model("clrst");

        // Reset mid-run at count 123 overrides a concurrent snap
        a_reset();
        a_rd_sel = 2'd1;
        a_idle(246);
        chk("mid.pre", a_rd_count, 123);
        a_rst = 1'b1; a_snap = 1'b1; a_start = 3'b111;
        a_cycle();
        a_rst = 1'b0; a_snap = 1'b0; a_start = '0;
        chk("mid.count", a_rd_count, 0);
        chk("mid.snap", a_rd_snap, 0);
        chk("mid.running", a_running, 3'b111);
        chk("mid.ovf", a_ovf, 0);
        chk("mid.led", a_led, 0);
        a_idle(7);
        chk("led.seven", a_led, 7);
        a_idle(1);
        chk("led.wrap", a_led, 0);
        a_snap = 1'b1; a_cycle(); a_snap = 1'b0;
        a_rd_sel = 2'd3;
        #1;
        chk("oob.count", a_rd_count, 0);
        chk("oob.snap", a_rd_snap, 0);
        a_rd_sel = 2'd0;
        #1;
        check_model("inb");

        // Randomized traffic with small register/data spaces so stop matches occur
        for (int i = 0; i < AN; i++) begin
            a_cfg_rd[5*i +: 5]    = 5'($urandom_range(0, 3));
            a_cfg_data[32*i +: 32] = 32'($urandom_range(0, 3));
        end
        for (int n = 0; n < 3000; n++) begin
            a_rst     = ($urandom_range(0, 149) == 0);
            a_wb_en   = 1'($urandom_range(0, 1));
            a_wb_rd   = 5'($urandom_range(0, 3));
            a_wb_data = 32'($urandom_range(0, 3));
            for (int i = 0; i < AN; i++) begin
                a_start[i] = ($urandom_range(0, 15) == 0);
                a_clr[i]   = ($urandom_range(0, 31) == 0);
            end
            a_snap   = ($urandom_range(0, 7) == 0);
            a_rd_sel = 2'($urandom_range(0, 3));
            a_cycle();
            check_model("rnd");
        end
        a_rst = 1'b0;
        a_idle(1);

        // Instance B: vector table, then saturation
        b_rst = 1'b0;
        for (int r = 0; r < 6; r++) begin
            b_start = tbl[r].start; b_clr = tbl[r].clr; b_snap = tbl[r].snap; b_rd_sel = tbl[r].sel;
            @(negedge clk);
            chk($sformatf("tbl%0d.count", r), b_rd_count, tbl[r].cnt);
            chk($sformatf("tbl%0d.snap", r), b_rd_snap, tbl[r].snp);
            chk($sformatf("tbl%0d.running", r), b_running, tbl[r].run);
            chk($sformatf("tbl%0d.done", r), b_done, tbl[r].dn);
            chk($sformatf("tbl%0d.ovf", r), b_ovf, tbl[r].ov);
        end
        b_start = '0; b_clr = '0; b_snap = 1'b0; b_rd_sel = 2'd1;
        repeat (9) @(negedge clk);
        chk("sat.14", b_rd_count, 14);
        chk("sat.14ovf", b_ovf[1], 0);
        @(negedge clk);
        chk("sat.15", b_rd_count, 15);
        chk("sat.15ovf", b_ovf[1], 0);
        @(negedge clk);
        chk("sat.hold", b_rd_count, 15);
        chk("sat.ovf", b_ovf[1], 1);
        repeat (20) @(negedge clk);
        chk("sat.sticky", b_ovf, 4'b0010);
        chk("sat.count", b_rd_count, 15);
        chk("sat.tick", b_tick, 1);
        b_start = 4'b0010;
        @(negedge clk);
        b_start = '0;
        chk("restart.count", b_rd_count, 0);
        chk("restart.ovf", b_ovf[1], 0);
        chk("restart.running", b_running[1], 1);
        @(negedge clk);
        chk("restart.inc", b_rd_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
